mult_div_seq: RTL and testbench
===============================

// Module: mult_div_seq
// PURPOSE
//   Multicycle sequencer for signed MULT and DIV. Takes operands from the A and B registers and
//   produces the Hi/Lo values. Drives the Hi/Lo write enables and the HiSel/LoSel mux selects.
//   Started and awaited by the main control unit through a start/busy/done handshake.
//   The control unit holds the instruction in a wait state until done.
// PARAMETERS
//   WIDTH   32   operand/result width; iteration count = WIDTH
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   start_mult  in   1      begin signed multiply (sampled in IDLE only)
//   start_div   in   1      begin signed divide (sampled in IDLE only)
//   op_a        in   WIDTH  multiplicand / dividend (A register)
//   op_b        in   WIDTH  multiplier / divisor (B register)
//   busy        out  1      high in every state except IDLE
//   done        out  1      one-cycle pulse, operation finished
//   div_zero    out  1      one-cycle pulse with done, divisor was zero
//   hi_result   out  WIDTH  Hi value (mult upper half / div remainder)
//   lo_result   out  WIDTH  Lo value (mult lower half / div quotient)
//   hi_sel      out  1      0 = divider result, 1 = multiplier result (HiSel)
//   lo_sel      out  1      same encoding as hi_sel (LoSel)
//   hi_write    out  1      HiWrite enable, one-cycle pulse
//   lo_write    out  1      LoWrite enable, one-cycle pulse
// BEHAVIOUR
//   Interface
//   - One clock. Reset is asynchronous and active-low.
//   - Reset (reset=0): state=IDLE. All outputs and internal registers = 0, effective immediately.
//     Reset mid-operation aborts with no done pulse.
//   FSM (states IDLE, MULT, DIV, FIX, DONE)
//   - IDLE -> MULT on start_mult, latch operands. IDLE -> DIV on start_div.
//   - Both starts high in the same cycle: MULT wins.
//   - Starts while busy are ignored (not queued).
//   - MULT: radix-2 Booth on {hi,lo,q-1}, one step per cycle.
//     WIDTH cycles, then DONE.
//   - DIV: restoring division on operand magnitudes, WIDTH cycles, then FIX.
//   - FIX: apply signs, one cycle, then DONE.
//     Quotient is negated if operand signs differ; remainder takes the dividend's sign.
//   - DONE (one cycle): done=1, hi_write=lo_write=1. hi_sel=lo_sel reflect the operation type.
//     Results are registered. Next state is IDLE.
//   - Divide by zero: IDLE -> DONE on the next edge. done=1, div_zero=1, hi_write=lo_write=0.
//     hi_result/lo_result keep their previous values.
//   Timing and widths
//   - Latency, start sampled at edge T: mult done at T+WIDTH+1; div done at T+WIDTH+2;
//     div-by-zero done at T+1.
//   - Mult: full 2*WIDTH-bit signed product. Hi = [2W-1:W], Lo = [W-1:0]. Never overflows.
//   - Div MIN/-1: quotient wraps to MIN, remainder 0. No exception is raised.
//   - Operand registers are loaded only in IDLE on start, so op_a/op_b may change while busy.
//   - hi_result/lo_result hold their values until the next successful operation completes.
//   - hi_sel/lo_sel hold the last operation type. Both are 0 after reset.
// STRUCTURE
//   - Shared package mdu_pkg:
//     - state encoding typedef (IDLE/MULT/DIV/FIX/DONE);
//     - HI_SEL_DIV=0, HI_SEL_MULT=1;
//     - default WIDTH.
//   - Contents of this file: FSM, iteration counter ($clog2(WIDTH)+1 bits), and
//     accumulator/quotient shift registers.
//   - No sub-module; a combinational helper function computes two's-complement magnitude.
// TESTING
//   1. mult 7 * 0xFFFFFFFD (-3) -> done at T+33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; hi_sel=1.
//   2. mult 0x80000000 * 0x80000000 -> Hi=0x40000000, Lo=0x00000000.
//   3. div 0xFFFFFFF9 (-7) / 2 -> done at T+34; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; hi_sel=0.
//   4. div 5 / 0 -> done and div_zero at T+1; no hi_write/lo_write; results unchanged from test 3.
//   5. start_mult and start_div both high, op 6,4 -> multiply runs; Lo=24, Hi=0.
//      A start_div pulse at T+10 is ignored.
//   6. Assert reset low at T+5 of a div -> busy, done and outputs go 0 without waiting for an edge.
//      A new mult 3*3 after release gives Lo=9.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
package mdu_pkg;

  // Default operand/result width.
  localparam int unsigned MDU_WIDTH = 32;

  // HiSel/LoSel mux encoding.
  localparam logic HI_SEL_DIV  = 1'b0;
  localparam logic HI_SEL_MULT = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StDiv,
    StFix,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mult_div_seq.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) sequencer with a
// start/busy/done handshake toward the main control unit.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result,
  output logic             hi_sel,
  output logic             lo_sel,
  output logic             hi_write,
  output logic             lo_write
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  // Two's-complement magnitude; MIN maps to 2^(WIDTH-1) read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // acc: Booth upper half (one guard bit) or division partial remainder.
  logic [WIDTH:0]   acc_q, acc_d;
  // quo: Booth multiplier/lower half or division dividend/quotient.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             qm1_q, qm1_d;
  // opr: multiplicand or divisor magnitude.
  logic [WIDTH-1:0] opr_q, opr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sel_q, sel_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             wr_q, wr_d;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      qm1_q     <= 1'b0;
      opr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      sel_q     <= HI_SEL_DIV;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      qm1_q     <= qm1_d;
      opr_q     <= opr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      wr_q      <= wr_d;
    end
  end

  // Next-state, iteration datapath and registered output pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    qm1_d     = qm1_q;
    opr_d     = opr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    wr_d      = 1'b0;
    booth_sum = '0;
    div_shift = '0;
    div_diff  = '0;

    unique case (state_q)
      StIdle: begin
        if (start_mult) begin
          state_d = StMult;
          cnt_d   = '0;
          acc_d   = '0;
          quo_d   = op_b;
          qm1_d   = 1'b0;
          opr_d   = op_a;
        end else if (start_div) begin
          if (op_b == '0) begin
            // Divide by zero: flag it, leave Hi/Lo untouched.
            state_d = StDone;
            sel_d   = HI_SEL_DIV;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d   = StDiv;
            cnt_d     = '0;
            acc_d     = '0;
            quo_d     = mag(op_a);
            opr_d     = mag(op_b);
            neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem_d = op_a[WIDTH-1];
          end
        end
      end

      StMult: begin
        case ({quo_q[0], qm1_q})
          2'b01:   booth_sum = acc_q + {opr_q[WIDTH-1], opr_q};
          2'b10:   booth_sum = acc_q - {opr_q[WIDTH-1], opr_q};
          default: booth_sum = acc_q;
        endcase
        // Arithmetic right shift of {acc, quo, q-1}.
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        quo_d = {booth_sum[0], quo_q[WIDTH-1:1]};
        qm1_d = quo_q[0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          hi_d    = acc_d[WIDTH-1:0];
          lo_d    = quo_d;
          sel_d   = HI_SEL_MULT;
          done_d  = 1'b1;
          wr_d    = 1'b1;
        end
      end

      StDiv: begin
        div_shift = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opr_q};
        if (!div_diff[WIDTH]) begin
          acc_d = div_diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end

      StFix: begin
        state_d = StDone;
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        sel_d   = HI_SEL_DIV;
        done_d  = 1'b1;
        wr_d    = 1'b1;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    div_zero  = dz_q;
    hi_result = hi_q;
    lo_result = lo_q;
    hi_sel    = sel_q;
    lo_sel    = sel_q;
    hi_write  = wr_q;
    lo_write  = wr_q;
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed, table-driven bench for mult_div_seq (WIDTH = 32).
module tb_mult_div_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_result;
  logic [W-1:0] lo_result;
  logic         hi_sel;
  logic         lo_sel;
  logic         hi_write;
  logic         lo_write;

  int n_total;
  int n_pass;

  mult_div_seq #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi_result (hi_result),
    .lo_result (lo_result),
    .hi_sel    (hi_sel),
    .lo_sel    (lo_sel),
    .hi_write  (hi_write),
    .lo_write  (lo_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_div;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation; lat is the cycle count from the sampling edge to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic sd, output int lat, output logic busy_early);
    op_a       = a;
    op_b       = b;
    start_mult = sm;
    start_div  = sd;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    busy_early = busy;
    lat        = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_done(input string tag, input int lat, input int exp_lat,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                            input logic exp_sel, input logic exp_dz);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi_result), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_result), 64'(exp_lo));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    check({tag, "_hi_write"}, 64'(hi_write), 64'(!exp_dz));
    check({tag, "_lo_write"}, 64'(lo_write), 64'(!exp_dz));
    check({tag, "_hi_sel"}, 64'(hi_sel), 64'(exp_sel));
    check({tag, "_lo_sel"}, 64'(lo_sel), 64'(exp_sel));
    // One cycle later the pulses are gone and results hold.
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'({done, hi_write, lo_write, div_zero, busy}), 64'd0);
    check({tag, "_hold"}, {hi_result, lo_result}, {exp_hi, exp_lo});
  endtask

  initial begin
    int   lat;
    logic busy_early;
    logic sel;
    int   exp_lat;

    n_total    = 0;
    n_pass     = 0;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;

    //            a             b             div   hi            lo            dz
    vecs[0]  = '{32'h00000007, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[3]  = '{32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001, 1'b0};
    vecs[5]  = '{32'h00000064, 32'h00000007, 1'b1, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0};
    vecs[9]  = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    // Divide by zero: Hi/Lo must still show the previous row's results.
    vecs[10] = '{32'h00000005, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};

    #1;
    check("reset_outputs", {busy, done, div_zero, hi_sel, lo_sel, hi_write, lo_write}, 64'd0);
    check("reset_results", {hi_result, lo_result}, 64'd0);
    #20;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, !vecs[i].is_div, vecs[i].is_div, lat, busy_early);
      if (vecs[i].dz) begin
        exp_lat = 1;
      end else if (vecs[i].is_div) begin
        exp_lat = W + 2;
      end else begin
        exp_lat = W + 1;
      end
      sel = vecs[i].is_div ? 1'b0 : 1'b1;
      if (!vecs[i].dz) begin
        check($sformatf("vec%0d_busy", i), 64'(busy_early), 64'd1);
      end
      check_done($sformatf("vec%0d", i), lat, exp_lat, vecs[i].hi, vecs[i].lo, sel, vecs[i].dz);
    end

    // Both starts together: multiply wins; a later start_div while busy is ignored.
    op_a       = 32'd6;
    op_b       = 32'd4;
    start_mult = 1'b1;
    start_div  = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    lat        = 1;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    op_a      = 32'd100;
    op_b      = 32'd0;
    start_div = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start_div = 1'b0;
    check("both_start_busy", 64'({busy, done}), 64'b10);
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_done("both_start", lat, W + 1, 32'd0, 32'd24, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a divide.
    op_a      = 32'd100;
    op_b      = 32'd7;
    start_div = 1'b1;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_ctrl", {busy, done, div_zero, hi_write, lo_write, hi_sel, lo_sel}, 64'd0);
    check("abort_results", {hi_result, lo_result}, 64'd0);
    @(posedge clk);
    #1;
    check("abort_no_done", 64'({busy, done}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd3, 32'd3, 1'b1, 1'b0, lat, busy_early);
    check("post_reset_busy", 64'(busy_early), 64'd1);
    check_done("post_reset", lat, W + 1, 32'd0, 32'd9, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
